// File: rtl/spike_event_fifo.sv
// Spike event FIFO: packs {pol, id} records, first-word-fall-through head.
// Optional head parity checking is enabled by defining SPIKE_FIFO_PARITY_EN.
module spike_event_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          spike_valid,
   input  logic          spike_pol,
   input  logic [6:0]    spike_id,
   input  logic          rd_en,
   input  logic          flush,
   input  logic          power_fail,
   output logic [7:0]    fifo_data_out,
   output logic          fifo_empty,
   output logic          fifo_full,
   output logic [AW:0]   level,
   output logic          overflow,
   output logic [7:0]    drop_count,
   output logic          parity_err
);

`ifdef SPIKE_FIFO_PARITY_EN
   localparam int W = 9;
`else
   localparam int W = 8;
`endif
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [7:0]    rec;
   logic [W-1:0]  wr_word;
   logic [W-1:0]  head_word;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    drop_cnt_q, drop_cnt_d;
   logic          wr_en, pop_ok;

   assign rec       = {spike_pol, spike_id};
   assign head_word = mem[rd_ptr_q];

`ifdef SPIKE_FIFO_PARITY_EN
   logic parity_err_q, parity_err_d;
   // bit 8 makes the 9-bit word even parity
   assign wr_word    = {^rec, rec};
   assign parity_err = parity_err_q;
`else
   assign wr_word    = rec;
   assign parity_err = 1'b0;
`endif

   assign fifo_empty    = (level_q == '0);
   assign fifo_full     = (level_q == LVL_FULL);
   assign level         = level_q;
   assign overflow      = overflow_q;
   assign drop_count    = drop_cnt_q;
   assign fifo_data_out = fifo_empty ? 8'h00 : head_word[7:0];

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      wr_en      = 1'b0;
      pop_ok     = 1'b0;
`ifdef SPIKE_FIFO_PARITY_EN
      parity_err_d = parity_err_q;
`endif
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         overflow_d = 1'b0;
`ifdef SPIKE_FIFO_PARITY_EN
         parity_err_d = 1'b0;
`endif
      end else if (power_fail) begin
         if (spike_valid && drop_cnt_q != 8'hFF)
            drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
         pop_ok = rd_en && !fifo_empty;
         // a full FIFO still accepts a push when the head leaves
         wr_en  = spike_valid && (!fifo_full || pop_ok);
         if (wr_en)
            wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok)
            rd_ptr_d = rd_ptr_q + 1'b1;
         level_d = level_q + (AW+1)'(wr_en) - (AW+1)'(pop_ok);
         if (spike_valid && !wr_en) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF)
               drop_cnt_d = drop_cnt_q + 8'd1;
         end
      end
`ifdef SPIKE_FIFO_PARITY_EN
      if (!flush && !fifo_empty && (^head_word))
         parity_err_d = 1'b1;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= 8'h00;
`ifdef SPIKE_FIFO_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
`ifdef SPIKE_FIFO_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr_q] <= wr_word;
   end

endmodule

// File: tb/tb_spike_event_fifo.sv
// Directed self-checking bench for spike_event_fifo (DEPTH=16).
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_spike_event_fifo;
   logic       clk = 1'b0;
   logic       rst;
   logic       spike_valid, spike_pol, rd_en, flush, power_fail;
   logic [6:0] spike_id;
   logic [7:0] fifo_data_out, drop_count;
   logic       fifo_empty, fifo_full, overflow, parity_err;
   logic [4:0] level;
   int         pass = 0;
   int         total = 0;

   spike_event_fifo #(.DEPTH(16), .AW(4)) dut (
      .clk(clk), .rst(rst),
      .spike_valid(spike_valid), .spike_pol(spike_pol), .spike_id(spike_id),
      .rd_en(rd_en), .flush(flush), .power_fail(power_fail),
      .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
      .fifo_full(fifo_full), .level(level), .overflow(overflow),
      .drop_count(drop_count), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic v, input logic [7:0] r, input logic rd,
                      input logic pf, input logic fl);
      spike_valid = v;
      spike_pol   = r[7];
      spike_id    = r[6:0];
      rd_en       = rd;
      power_fail  = pf;
      flush       = fl;
      @(posedge clk);
      #1;
      spike_valid = 1'b0;
      rd_en       = 1'b0;
      power_fail  = 1'b0;
      flush       = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      spike_valid = 1'b0; spike_pol = 1'b0; spike_id = '0;
      rd_en = 1'b0; flush = 1'b0; power_fail = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      total++;
      if ({level, fifo_empty, fifo_full, overflow, drop_count, fifo_data_out,
           parity_err} !== {5'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0})
         $display("FAIL reset: lvl=%0d e=%b f=%b ov=%b dc=%0d d=%h pe=%b",
                  level, fifo_empty, fifo_full, overflow, drop_count,
                  fifo_data_out, parity_err);
      else pass++;
   endtask

   task automatic test_basic;
      logic [7:0] exp_h [3] = '{8'h05, 8'h7F, 8'h00};
      cyc(1, 8'h81, 0, 0, 0);
      total++;
      if (fifo_data_out !== 8'h81 || fifo_empty !== 1'b0)
         $display("FAIL basic_first_head: got %h e=%b want 81", fifo_data_out, fifo_empty);
      else pass++;
      cyc(1, 8'h05, 0, 0, 0);
      cyc(1, 8'h7F, 0, 0, 0);
      total++;
      if (level !== 5'd3 || fifo_data_out !== 8'h81)
         $display("FAIL basic_level3: lvl=%0d head=%h want 3/81", level, fifo_data_out);
      else pass++;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 8'h00, 1, 0, 0);
         total++;
         if (fifo_data_out !== exp_h[i])
            $display("FAIL basic_pop%0d: got %h want %h", i, fifo_data_out, exp_h[i]);
         else pass++;
      end
      total++;
      if (fifo_empty !== 1'b1 || level !== 5'd0)
         $display("FAIL basic_empty: e=%b lvl=%0d want 1/0", fifo_empty, level);
      else pass++;
      cyc(0, 8'h00, 1, 0, 0);
      total++;
      if (level !== 5'd0 || fifo_empty !== 1'b1)
         $display("FAIL basic_pop_empty: lvl=%0d want 0", level);
      else pass++;
   endtask

   task automatic test_overflow;
      for (int i = 0; i < 17; i++) cyc(1, 8'(8'h90 + i), 0, 0, 0);
      total++;
      if (fifo_full !== 1'b1 || level !== 5'd16 || overflow !== 1'b1 ||
          drop_count !== 8'd1)
         $display("FAIL ovf_flags: f=%b lvl=%0d ov=%b dc=%0d want 1/16/1/1",
                  fifo_full, level, overflow, drop_count);
      else pass++;
      for (int i = 0; i < 16; i++) begin
         total++;
         if (fifo_data_out !== 8'(8'h90 + i))
            $display("FAIL ovf_drain%0d: got %h want %h", i, fifo_data_out, 8'(8'h90 + i));
         else pass++;
         cyc(0, 8'h00, 1, 0, 0);
      end
      total++;
      if (fifo_empty !== 1'b1 || overflow !== 1'b1)
         $display("FAIL ovf_after_drain: e=%b ov=%b want 1/1", fifo_empty, overflow);
      else pass++;
   endtask

   task automatic test_full_push_pop;
      cyc(0, 8'h00, 0, 0, 1);
      total++;
      if (overflow !== 1'b0 || drop_count !== 8'd1)
         $display("FAIL fpp_flush: ov=%b dc=%0d want 0/1", overflow, drop_count);
      else pass++;
      for (int i = 0; i < 16; i++) cyc(1, 8'(8'h40 + i), 0, 0, 0);
      cyc(1, 8'h22, 1, 0, 0);
      total++;
      if (level !== 5'd16 || overflow !== 1'b0 || fifo_full !== 1'b1 ||
          fifo_data_out !== 8'h41)
         $display("FAIL fpp_level: lvl=%0d ov=%b f=%b head=%h want 16/0/1/41",
                  level, overflow, fifo_full, fifo_data_out);
      else pass++;
      for (int i = 1; i < 17; i++) begin
         total++;
         if (fifo_data_out !== ((i == 16) ? 8'h22 : 8'(8'h40 + i)))
            $display("FAIL fpp_drain%0d: got %h want %h", i, fifo_data_out,
                     (i == 16) ? 8'h22 : 8'(8'h40 + i));
         else pass++;
         cyc(0, 8'h00, 1, 0, 0);
      end
      total++;
      if (fifo_empty !== 1'b1 || drop_count !== 8'd1)
         $display("FAIL fpp_end: e=%b dc=%0d want 1/1", fifo_empty, drop_count);
      else pass++;
   endtask

   task automatic test_power_fail;
      for (int i = 0; i < 5; i++) cyc(1, 8'(8'h10 + i), 0, 0, 0);
      spike_valid = 1'b1; spike_id = 7'h55; rd_en = 1'b1; power_fail = 1'b1;
      repeat (4) @(posedge clk);
      #1 power_fail = 1'b0; spike_valid = 1'b0; rd_en = 1'b0;
      total++;
      if (level !== 5'd5 || fifo_data_out !== 8'h10 || drop_count !== 8'd5 ||
          overflow !== 1'b0)
         $display("FAIL pf_hold: lvl=%0d head=%h dc=%0d ov=%b want 5/10/5/0",
                  level, fifo_data_out, drop_count, overflow);
      else pass++;
      cyc(0, 8'h00, 1, 0, 0);
      total++;
      if (level !== 5'd4 || fifo_data_out !== 8'h11)
         $display("FAIL pf_resume: lvl=%0d head=%h want 4/11", level, fifo_data_out);
      else pass++;
   endtask

   task automatic test_flush_rst;
      for (int i = 0; i < 3; i++) cyc(1, 8'(8'h60 + i), 0, 0, 0);
      total++;
      if (level !== 5'd7)
         $display("FAIL fl_pre: lvl=%0d want 7", level);
      else pass++;
      cyc(1, 8'hAA, 0, 0, 1);
      total++;
      if (level !== 5'd0 || fifo_empty !== 1'b1 || drop_count !== 8'd5 ||
          fifo_data_out !== 8'h00)
         $display("FAIL flush: lvl=%0d e=%b dc=%0d d=%h want 0/1/5/00",
                  level, fifo_empty, drop_count, fifo_data_out);
      else pass++;
      cyc(1, 8'h01, 0, 0, 0);
      cyc(1, 8'h02, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      total++;
      if ({level, fifo_empty, fifo_full, overflow, drop_count, fifo_data_out}
          !== {5'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0})
         $display("FAIL async_rst: lvl=%0d e=%b dc=%0d d=%h want 0/1/0/00",
                  level, fifo_empty, drop_count, fifo_data_out);
      else pass++;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_back_to_back;
      cyc(1, 8'h33, 1, 0, 0);
      total++;
      if (level !== 5'd1 || fifo_data_out !== 8'h33)
         $display("FAIL b2b_empty: lvl=%0d head=%h want 1/33", level, fifo_data_out);
      else pass++;
      cyc(1, 8'h44, 1, 0, 0);
      total++;
      if (level !== 5'd1 || fifo_data_out !== 8'h44)
         $display("FAIL b2b_mid: lvl=%0d head=%h want 1/44", level, fifo_data_out);
      else pass++;
   endtask

   task automatic test_saturate;
      for (int i = 0; i < 15; i++) cyc(1, 8'(i), 0, 0, 0);
      spike_valid = 1'b1;
      repeat (260) @(posedge clk);
      #1 spike_valid = 1'b0;
      total++;
      if (drop_count !== 8'd255 || overflow !== 1'b1 || level !== 5'd16)
         $display("FAIL sat: dc=%0d ov=%b lvl=%0d want 255/1/16",
                  drop_count, overflow, level);
      else pass++;
      cyc(1, 8'h00, 0, 1, 0);
      total++;
      if (drop_count !== 8'd255 || parity_err !== 1'b0)
         $display("FAIL sat_pf: dc=%0d pe=%b want 255/0", drop_count, parity_err);
      else pass++;
   endtask

`ifdef SPIKE_FIFO_PARITY_EN
   task automatic test_parity;
      cyc(0, 8'h00, 0, 0, 1);
      cyc(1, 8'h81, 0, 0, 0);
      cyc(1, 8'h05, 0, 0, 0);
      total++;
      if (parity_err !== 1'b0)
         $display("FAIL par_clean: pe=%b want 0", parity_err);
      else pass++;
      dut.mem[0][0] = ~dut.mem[0][0];
      @(posedge clk);
      #1;
      total++;
      if (parity_err !== 1'b1 || fifo_data_out !== 8'h80)
         $display("FAIL par_set: pe=%b d=%h want 1/80", parity_err, fifo_data_out);
      else pass++;
      cyc(0, 8'h00, 1, 0, 0);
      total++;
      if (parity_err !== 1'b1)
         $display("FAIL par_sticky: pe=%b want 1", parity_err);
      else pass++;
      cyc(0, 8'h00, 0, 0, 1);
      total++;
      if (parity_err !== 1'b0)
         $display("FAIL par_flush: pe=%b want 0", parity_err);
      else pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_full_push_pop();
      test_power_fail();
      test_flush_rst();
      test_back_to_back();
      test_saturate();
`ifdef SPIKE_FIFO_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim time exceeded");
      $fatal(1);
   end
endmodule
